// File: rtl/palette_pkg.sv
// ---------------------------------------------------------------------------
// palette_pkg
// Shared types and constants for the palette lookup block.
//   rgb12_t       : packed {r, g, b} 4-bit-per-channel colour
//   LEVEL_MAX     : full-brightness fade level (identity scaling)
//   fade_state_e  : fade controller states (IDLE, RUN)
//   scale_chan()  : (c * level) >> 4 for one channel
// ---------------------------------------------------------------------------
package palette_pkg;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [0:0] {
    FADE_IDLE = 1'b0,
    FADE_RUN  = 1'b1
  } fade_state_e;

  // Largest product is 15 * 16 = 240, so 8 bits hold it without overflow.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] level);
    logic [7:0] prod;
    prod = {4'b0000, c} * {3'b000, level};
    return 4'(prod >> 4);
  endfunction

endpackage

// File: rtl/palette_fader.sv
// ---------------------------------------------------------------------------
// palette_fader
// Brightness fade controller: steps a 0..16 level toward a target of 0
// (fade out) or 16 (fade in), one step every FADE_STEP_FRAMES frame ticks.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   fade_start_i   : start a fade (ignored while running)
//   fade_dir_i     : 1 = fade in (target 16), 0 = fade out (target 0)
//   frame_tick_i   : one-cycle pulse per frame
//   state_o        : current controller state (RUN means busy)
//   level_o        : current brightness level 0..16
// ---------------------------------------------------------------------------
import palette_pkg::*;

module palette_fader #(
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fade_start_i,
  input  logic        fade_dir_i,
  input  logic        frame_tick_i,
  output fade_state_e state_o,
  output logic [4:0]  level_o
);

  localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

  fade_state_e      state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [4:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       step_level;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    // One step toward the target; the target is always 0 or 16, so the
    // level can never leave 0..16.
    step_level = level_q;
    if (target_q > level_q)      step_level = level_q + 5'd1;
    else if (target_q < level_q) step_level = level_q - 5'd1;

    case (state_q)
      FADE_IDLE: begin
        if (fade_start_i) begin
          state_d  = FADE_RUN;
          target_d = fade_dir_i ? LEVEL_MAX : 5'd0;
          cnt_d    = '0;
        end
      end
      FADE_RUN: begin
        // Only reachable when a fade was started with the level already
        // at its target: spend one cycle busy, then return.
        if (level_q == target_q) begin
          state_d = FADE_IDLE;
        end else if (frame_tick_i) begin
          if (cnt_q == CNT_LAST) begin
            level_d = step_level;
            cnt_d   = '0;
            if (step_level == target_q) state_d = FADE_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FADE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FADE_IDLE;
      level_q  <= LEVEL_MAX;
      target_q <= LEVEL_MAX;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign level_o = level_q;

endmodule

// File: rtl/palette_bank_lut.sv
// ---------------------------------------------------------------------------
// palette_bank_lut
// Multi-bank 12-bit RGB palette with a 2-cycle lookup pipeline
// (stage 1: table read, stage 2: brightness scaling) and optional fade.
// Build option: define PALETTE_FADE_EN to include the fade controller;
// without it the level is fixed at 16 and colours pass through unscaled.
// Ports:
//   Clk, Reset                 : clock, asynchronous active-high reset
//   pix_valid, bank_sel, index : lookup request, one per cycle
//   red, green, blue           : scaled colour, valid with rgb_valid
//   rgb_valid                  : pix_valid delayed by 2 cycles
//   transparent                : looked-up index was 0, aligned with rgb
//   wr_en, wr_bank, wr_index, wr_data : table write port ({R,G,B})
//   frame_tick, fade_start, fade_dir  : fade control inputs
//   fade_busy, fade_level             : fade status
// Handshake: pix_valid is a pure strobe, no backpressure; every request
// produces exactly one rgb_valid pulse two cycles later.
// ---------------------------------------------------------------------------
import palette_pkg::*;

module palette_bank_lut #(
  parameter int IDX_W            = 3,
  parameter int NUM_BANKS        = 4,
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         pix_valid,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  input  logic [IDX_W-1:0]             index,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic                         rgb_valid,
  output logic                         transparent,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [IDX_W-1:0]             wr_index,
  input  logic [11:0]                  wr_data,
  input  logic                         frame_tick,
  input  logic                         fade_start,
  input  logic                         fade_dir,
  output logic                         fade_busy,
  output logic [4:0]                   fade_level
);

  localparam int ENTRIES = 1 << IDX_W;

  rgb12_t tbl_q [NUM_BANKS][ENTRIES];

  logic   s1_valid_q, s1_transp_q;
  rgb12_t s1_rgb_q;
  logic   out_valid_q, out_transp_q;
  rgb12_t out_rgb_q, out_rgb_d;

  // Table: the stage-1 register samples the pre-write contents, so a
  // same-cycle write and read of one entry returns the old data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          tbl_q[b][e] <= '0;
        end
      end
    end else if (wr_en) begin
      tbl_q[wr_bank][wr_index] <= wr_data;
    end
  end

`ifdef PALETTE_FADE_EN
  fade_state_e fade_state;

  palette_fader #(
    .FADE_STEP_FRAMES(FADE_STEP_FRAMES)
  ) u_fader (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .fade_start_i (fade_start),
    .fade_dir_i   (fade_dir),
    .frame_tick_i (frame_tick),
    .state_o      (fade_state),
    .level_o      (fade_level)
  );

  assign fade_busy = (fade_state == FADE_RUN);

  always_comb begin
    out_rgb_d.r = scale_chan(s1_rgb_q.r, fade_level);
    out_rgb_d.g = scale_chan(s1_rgb_q.g, fade_level);
    out_rgb_d.b = scale_chan(s1_rgb_q.b, fade_level);
  end
`else
  localparam int unused_step_frames = FADE_STEP_FRAMES;
  logic unused_fade_inputs;

  assign unused_fade_inputs = ^{frame_tick, fade_start, fade_dir};
  assign fade_level         = LEVEL_MAX;
  assign fade_busy          = 1'b0;
  assign out_rgb_d          = s1_rgb_q;
`endif

  // Two pipeline stages; both are cleared by reset so in-flight lookups
  // are dropped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q   <= 1'b0;
      s1_transp_q  <= 1'b0;
      s1_rgb_q     <= '0;
      out_valid_q  <= 1'b0;
      out_transp_q <= 1'b0;
      out_rgb_q    <= '0;
    end else begin
      s1_valid_q   <= pix_valid;
      s1_transp_q  <= (index == '0);
      s1_rgb_q     <= tbl_q[bank_sel][index];
      out_valid_q  <= s1_valid_q;
      out_transp_q <= s1_valid_q & s1_transp_q;
      out_rgb_q    <= out_rgb_d;
    end
  end

  assign red         = out_rgb_q.r;
  assign green       = out_rgb_q.g;
  assign blue        = out_rgb_q.b;
  assign rgb_valid   = out_valid_q;
  assign transparent = out_transp_q;

endmodule

// File: tb/tb_palette_bank_lut.sv
// ---------------------------------------------------------------------------
// tb_palette_bank_lut
// Directed and random lookups against a shadow palette table. Expected
// outputs are queued per issued cycle and compared two cycles later.
// ---------------------------------------------------------------------------
module tb_palette_bank_lut;

  localparam int IDX_W     = 3;
  localparam int NUM_BANKS = 4;
  localparam int ENTRIES   = 8;

  // Clock / reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic        pix_valid, wr_en, frame_tick, fade_start, fade_dir;
  logic [1:0]  bank_sel, wr_bank;
  logic [2:0]  index, wr_index;
  logic [11:0] wr_data;
  logic [3:0]  red, green, blue;
  logic        rgb_valid, transparent, fade_busy;
  logic [4:0]  fade_level;

  palette_bank_lut #(
    .IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS), .FADE_STEP_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .bank_sel(bank_sel),
    .index(index), .red(red), .green(green), .blue(blue),
    .rgb_valid(rgb_valid), .transparent(transparent), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
    .fade_busy(fade_busy), .fade_level(fade_level)
  );

  // Scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [11:0] model_tbl [NUM_BANKS][ENTRIES];
  logic [13:0] exp_q[$];   // {valid, transparent, rgb}
  int          m_level = 16;

  function automatic logic [3:0] sc(input logic [3:0] c, input int lvl);
    return 4'((int'(c) * lvl) / 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle with a lookup and optional write. Fade controls
  // are set by the caller beforehand and cleared after the edge.
  task automatic cycle(input logic pv, input logic [1:0] b, input logic [2:0] i,
                       input logic we, input logic [1:0] wb, input logic [2:0] wi,
                       input logic [11:0] wd);
    logic [11:0] e;
    logic [13:0] x;
    pix_valid = pv; bank_sel = b; index = i;
    wr_en = we; wr_bank = wb; wr_index = wi; wr_data = wd;
    e = model_tbl[b][i];
    x = {pv, pv && (i == 3'd0), sc(e[11:8], m_level), sc(e[7:4], m_level), sc(e[3:0], m_level)};
    exp_q.push_back(x);
    @(posedge Clk); #1;
    frame_tick = 1'b0; fade_start = 1'b0;
    if (we) model_tbl[wb][wi] = wd;
    if (exp_q.size() >= 2) begin
      x = exp_q.pop_front();
      check("pipe_valid", 32'(rgb_valid), 32'(x[13]));
      check("pipe_transp", 32'(transparent), 32'(x[12]));
      if (x[13]) check("pipe_rgb", 32'({red, green, blue}), 32'(x[11:0]));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 12'h000);
  endtask

  task automatic clear_model();
    for (int b = 0; b < NUM_BANKS; b++)
      for (int e = 0; e < ENTRIES; e++) model_tbl[b][e] = 12'h000;
    exp_q.delete();
  endtask

  initial begin
    Reset = 1'b1;
    pix_valid = 0; bank_sel = 0; index = 0; wr_en = 0; wr_bank = 0;
    wr_index = 0; wr_data = 0; frame_tick = 0; fade_start = 0; fade_dir = 0;
    clear_model();
    @(posedge Clk); @(posedge Clk); #1;

    // Reset state
    check("rst_valid", 32'(rgb_valid), 32'd0);
    check("rst_transp", 32'(transparent), 32'd0);
    check("rst_rgb", 32'({red, green, blue}), 32'h000);
    check("rst_level", 32'(fade_level), 32'd16);
    check("rst_busy", 32'(fade_busy), 32'd0);
    Reset = 1'b0;

    // Write then read bank 1 idx 5
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 2'd1, 3'd5, 12'hF84);
    cycle(1'b1, 2'd1, 3'd5, 1'b0, 2'd0, 3'd0, 12'h000);
    check("lat_not_early", 32'(rgb_valid), 32'd0);
    idle();
    check("f84_valid", 32'(rgb_valid), 32'd1);
    check("f84_rgb", 32'({red, green, blue}), 32'hF84);
    check("f84_transp", 32'(transparent), 32'd0);

    // Same-cycle write and read: old data first, new data next
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 2'd0, 3'd2, 12'h123);
    cycle(1'b1, 2'd0, 3'd2, 1'b1, 2'd0, 3'd2, 12'hABC);
    cycle(1'b1, 2'd0, 3'd2, 1'b0, 2'd0, 3'd0, 12'h000);
    check("rbw_old", 32'({red, green, blue}), 32'h123);
    idle();
    check("rbw_new", 32'({red, green, blue}), 32'hABC);

    // Index 0 is transparent regardless of contents
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 2'd2, 3'd0, 12'h0F0);
    cycle(1'b1, 2'd2, 3'd0, 1'b0, 2'd0, 3'd0, 12'h000);
    idle();
    check("idx0_rgb", 32'({red, green, blue}), 32'h0F0);
    check("idx0_transp", 32'(transparent), 32'd1);

    // Random traffic at full brightness
    for (int n = 0; n < 200; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            12'($urandom_range(0, 4095)));
    end
    idle(); idle();

`ifdef PALETTE_FADE_EN
    // Fade start with level already at target: one busy cycle, level kept
    fade_dir = 1'b1; fade_start = 1'b1; idle();
    check("at_tgt_busy", 32'(fade_busy), 32'd1);
    check("at_tgt_level", 32'(fade_level), 32'd16);
    idle();
    check("at_tgt_idle", 32'(fade_busy), 32'd0);
    check("at_tgt_level2", 32'(fade_level), 32'd16);

    // Fade out of a white entry over 32 ticks
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 2'd3, 3'd1, 12'hFFF);
    fade_dir = 1'b0; fade_start = 1'b1; idle();
    check("fo_busy", 32'(fade_busy), 32'd1);
    for (int t = 1; t <= 32; t++) begin
      frame_tick = 1'b1; idle();
      m_level = 16 - t / 2;
      check("fo_level", 32'(fade_level), 32'(m_level));
      check("fo_busy_t", 32'(fade_busy), 32'(t < 32));
      if (t == 16) begin
        cycle(1'b1, 2'd3, 3'd1, 1'b0, 2'd0, 3'd0, 12'h000);
        idle();
        check("fo_half_rgb", 32'({red, green, blue}), 32'h777);
      end
    end

    // Fade in; a fade_start at level 5 is ignored
    fade_dir = 1'b1; fade_start = 1'b1; idle();
    for (int t = 1; t <= 10; t++) begin
      frame_tick = 1'b1; idle();
    end
    check("fi_level5", 32'(fade_level), 32'd5);
    fade_dir = 1'b0; fade_start = 1'b1; idle();
    check("fi_ign_busy", 32'(fade_busy), 32'd1);
    check("fi_ign_level", 32'(fade_level), 32'd5);
    fade_dir = 1'b1;
    for (int t = 11; t <= 32; t++) begin
      frame_tick = 1'b1; idle();
      check("fi_level", 32'(fade_level), 32'(t / 2));
    end
    check("fi_done_busy", 32'(fade_busy), 32'd0);
    m_level = 16;

    // Fade out to level 9 before the reset test
    fade_dir = 1'b0; fade_start = 1'b1; idle();
    for (int t = 1; t <= 14; t++) begin
      frame_tick = 1'b1; idle();
    end
    check("pre_rst_level", 32'(fade_level), 32'd9);
    check("pre_rst_busy", 32'(fade_busy), 32'd1);
`else
    // Fade controls have no effect in this build
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 2'd3, 3'd1, 12'hFFF);
    fade_dir = 1'b0; fade_start = 1'b1; idle();
    check("nofade_busy", 32'(fade_busy), 32'd0);
    for (int t = 1; t <= 6; t++) begin
      frame_tick = 1'b1; idle();
      check("nofade_level", 32'(fade_level), 32'd16);
      check("nofade_busy_t", 32'(fade_busy), 32'd0);
    end
    cycle(1'b1, 2'd3, 3'd1, 1'b0, 2'd0, 3'd0, 12'h000);
    idle();
    check("nofade_rgb", 32'({red, green, blue}), 32'hFFF);
`endif

    // Reset mid-operation with lookups in flight
    pix_valid = 1'b1; bank_sel = 2'd1; index = 3'd5; wr_en = 1'b0;
    @(posedge Clk); #1;
    bank_sel = 2'd3; index = 3'd1;
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rgb_valid), 32'd0);
    check("mid_rst_rgb", 32'({red, green, blue}), 32'h000);
    check("mid_rst_transp", 32'(transparent), 32'd0);
    check("mid_rst_level", 32'(fade_level), 32'd16);
    check("mid_rst_busy", 32'(fade_busy), 32'd0);
    pix_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    clear_model();
    m_level = 16;
    check("post_rst_valid", 32'(rgb_valid), 32'd0);

    // First post-reset lookup appears exactly two cycles later, reading zero
    cycle(1'b1, 2'd1, 3'd5, 1'b0, 2'd0, 3'd0, 12'h000);
    check("post_rst_lat", 32'(rgb_valid), 32'd0);
    cycle(1'b1, 2'd3, 3'd1, 1'b0, 2'd0, 3'd0, 12'h000);
    check("post_rst_first", 32'(rgb_valid), 32'd1);
    check("post_rst_zero", 32'({red, green, blue}), 32'h000);
    idle();
    check("post_rst_zero2", 32'({red, green, blue}), 32'h000);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palette_bank_lut.md
PALETTE_BANK_LUT -- requirements
Module: palette_bank_lut

Interface
REQ-001 SHALL have parameter IDX_W, default 3, meaning the colour index width, giving 2**IDX_W entries per bank.
REQ-002 SHALL have parameter NUM_BANKS, default 4, meaning the number of independent palettes; BANK_W = $clog2(NUM_BANKS).
REQ-003 SHALL have parameter FADE_STEP_FRAMES, default 2, meaning frame_ticks per fade level step; legal range >= 1.
REQ-004 SHALL have ports, in order:
  Clk  in  1  single clock, rising edge;
  Reset  in  1  asynchronous, active-high;
  pix_valid  in  1  lookup request;
  bank_sel  in  BANK_W  palette select;
  index  in  IDX_W  colour index;
  red/green/blue  out  4 each  scaled colour;
  rgb_valid  out  1  pix_valid delayed by 2;
  transparent  out  1  index was 0, aligned with rgb;
  wr_en  in  1  table write strobe;
  wr_bank  in  BANK_W  write target bank;
  wr_index  in  IDX_W  write target entry;
  wr_data  in  12  {R,G,B} nibbles;
  frame_tick  in  1  one-cycle pulse per frame;
  fade_start  in  1  start fade;
  fade_dir  in  1  1 = fade in, 0 = fade out;
  fade_busy  out  1  fade running;
  fade_level  out  5  current brightness 0..16.

Function
REQ-005 SHALL hold NUM_BANKS x 2**IDX_W entries of 12-bit RGB, written on any Clk edge with wr_en=1.
REQ-006 SHALL return a lookup with fixed 2-cycle latency: stage 1 table read, stage 2 scaling; issue rate one per cycle, no stalls.
REQ-007 SHALL resolve a write and read of the same entry in the same cycle read-before-write: the read returns the old data.
REQ-008 SHALL scale each channel as out = (c * fade_level) >> 4, using the fade_level sampled at stage 2; level 16 is identity, level 0 is black.
REQ-009 SHALL assert transparent when the stage-1 index was 0, independent of table contents and fade level.
REQ-010 SHALL run the fade FSM with states IDLE, RUN:
  IDLE->RUN on fade_start; target = 16 if fade_dir else 0; the frame counter is cleared on entry.
  In RUN, each frame_tick increments the frame counter.
  On the FADE_STEP_FRAMES-th tick, level steps +/-1 toward the target and the counter clears.
  RUN->IDLE in the cycle level reaches the target.
REQ-011 SHALL ignore fade_start while fade_busy=1; fade_busy=1 exactly while the FSM is in RUN.
REQ-012 SHALL, on fade_start with the level already at the target, enter RUN and return to IDLE on the next cycle with the level unchanged.
REQ-013 SHALL keep the level saturated within 0..16; no wrap-around.

Reset
REQ-014 SHALL on Reset, asynchronously:
  clear every table entry to 12'h000;
  clear rgb_valid, transparent, red, green, blue to 0;
  clear the pipeline valid bits;
  set the FSM to IDLE, fade_busy=0, fade_level=16, frame counter 0.
REQ-015 SHALL discard any in-flight lookups and any running fade on Reset mid-operation; the first valid output appears 2 cycles after the first post-reset pix_valid.

Configuration
REQ-016 SHALL, with PALETTE_FADE_EN defined, implement REQ-008 and REQ-010..013 as stated.
REQ-017 SHALL, without PALETTE_FADE_EN:
  tie fade_level to 16 and fade_busy to 0;
  ignore fade_start, fade_dir and frame_tick;
  pass table data unscaled;
  keep the 2-cycle latency unchanged.

Structure
REQ-018 SHALL place typedef rgb12_t (3 x 4-bit struct), the constant LEVEL_MAX=16 and the fade state enum in shared package palette_pkg.
REQ-019 SHALL implement the fade FSM and level counter as sub-module palette_fader, instantiated only under PALETTE_FADE_EN.

Verification
REQ-020 Write bank 1 idx 5 = 12'hF84, then read bank 1 idx 5 -> two cycles later rgb = F,8,4, rgb_valid=1, transparent=0.
REQ-021 Write and read of bank 0 idx 2 (old 12'h123, new 12'hABC) in the same cycle -> read returns 1,2,3; the next read returns A,B,C.
REQ-022 Entry 12'hFFF, fade_dir=0, FADE_STEP_FRAMES=2, 32 frame_ticks -> level reaches 0 after the 32nd tick and fade_busy drops; at level 8 the output is 7,7,7.
REQ-023 Fade-in running, fade_start with fade_dir=0 at level 5 -> ignored; the fade continues to 16.
REQ-024 Read idx 0 with entry 12'h0F0 -> rgb = 0,F,0 with transparent=1.
REQ-025 Reset asserted during a fade at level 9 with lookups in flight -> outputs 0, fade_level=16, fade_busy=0 immediately; the table reads zero afterwards.
